imem_loader: RTL

Writer side of the instruction memory. It accepts a byte stream over a valid/ready handshake and assembles the bytes into little-endian 32-bit words. Each word is written into a writable instruction RAM at consecutive word-aligned byte addresses, the same address format the CPU uses on its fetch port. While a load is in progress it asserts `cpu_hold` to keep the core stalled.

---
 rtl/imem_loader.sv | 103 ++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Instruction memory loader: packs a byte stream into little-endian words
// and writes them to consecutive word addresses while holding the CPU.
module imem_loader #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              we,
    output logic [31:0]       waddr,
    output logic [31:0]       wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]        state;
    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        byte_idx;
    logic              last_seen;
    logic [31:0]       buffer;
    logic [31:0]       buf_nx;
    logic              accept;

    assign in_ready = (state == LOAD);
    assign we       = (state == WRITE);
    assign cpu_hold = (state == LOAD) || (state == WRITE);
    assign done     = (state == DONE);
    assign accept   = in_valid && in_ready;

    // Upper bytes stay zero because the buffer is cleared between words.
    always_comb begin
        buf_nx = buffer;
        buf_nx[{byte_idx, 3'b000} +: 8] = in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            waddr        <= '0;
            wdata        <= '0;
            error        <= 1'b0;
            words_loaded <= '0;
            word_idx     <= '0;
            byte_idx     <= '0;
            last_seen    <= 1'b0;
            buffer       <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state        <= LOAD;
                        error        <= 1'b0;
                        words_loaded <= '0;
                        word_idx     <= '0;
                        byte_idx     <= '0;
                        last_seen    <= 1'b0;
                        buffer       <= '0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        buffer   <= buf_nx;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3 || in_last) begin
                            state     <= WRITE;
                            last_seen <= in_last;
                            waddr     <= {{(30-ADDR_W){1'b0}}, word_idx, 2'b00};
                            wdata     <= buf_nx;
                        end
                    end
                end
                WRITE: begin
                    word_idx     <= word_idx + 1'b1;
                    words_loaded <= words_loaded + 1'b1;
                    byte_idx     <= '0;
                    buffer       <= '0;
                    if (last_seen) begin
                        state <= DONE;
                    end else if (word_idx == ADDR_W'(DEPTH-1)) begin
                        state <= DONE;
                        error <= 1'b1;
                    end else begin
                        state <= LOAD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
